reg_file_clr: RTL and testbench
===============================

// Module: reg_file_clr
// PURPOSE
//  Parametrised multi-port register file; generalises the single-register storage element.
//  DEPTH x WIDTH storage with NREAD combinational read ports and one write port.
//  Optional hard-wired zero at entry 0, same-cycle write-to-read forwarding, and a
//  sequenced bulk-clear engine (one entry per cycle, busy flag).
//  Sits in the decode stage of the unicycle datapath as the architectural GPR file.
// PARAMETERS
//  WIDTH     32  data width of each entry, >=1
//  DEPTH     32  number of entries, >=2; AW = $clog2(DEPTH)
//  NREAD     2   number of read ports, >=1
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           asynchronous, active-low reset
//  we         in   1           write enable
//  waddr      in   AW          write address
//  wdata      in   WIDTH       write data
//  raddr      in   NREAD*AW    read addresses, port k at [k*AW +: AW]
//  rdata      out  NREAD*WIDTH read data, port k at [k*WIDTH +: WIDTH]
//  clear_req  in   1           start bulk clear (sampled in IDLE only)
//  busy       out  1           clear sequence in progress
//  wr_drop    out  1           write presented but discarded this cycle
// BEHAVIOUR
//  Reset (rst=0, async): all entries <- 0, FSM <- IDLE, clear index <- 0; busy=0.
//  rdata then 0 on every port; wr_drop=0.
//  Write: at posedge, if we && state==IDLE && waddr<DEPTH && !(ZERO_REG && waddr==0),
//  then mem[waddr] <- wdata; else no storage change.
//  wr_drop (comb) = we && (state==CLEAR || waddr>=DEPTH || (ZERO_REG && waddr==0)).
//  Read (comb, zero latency), per port k with a=raddr[k]:
//  - a>=DEPTH, or ZERO_REG && a==0 -> 0
//  - else if state==IDLE && we && waddr==a -> wdata (forward)
//  - else -> mem[a].
//  Multiple read ports on same address return identical data.
//  FSM states IDLE, CLEAR.
//  - IDLE: clear_req=1 at posedge N -> CLEAR, idx<=0.
//    A write in the same cycle is still performed at edge N (cleared later).
//  - CLEAR: each posedge mem[idx]<=0, idx<=idx+1.
//    On idx==DEPTH-1, clear that entry and return to IDLE, idx<=0.
//  - busy = (state==CLEAR): high exactly DEPTH cycles (edges N+1..N+DEPTH do the clearing).
//  - In CLEAR: clear_req ignored (no restart, no queueing); writes dropped (wr_drop=1);
//    reads return stored mem contents, no forwarding, partially cleared values visible.
//  - Reset mid-CLEAR: immediate full clear, IDLE, busy=0.
//  idx counter is AW+1 bits wide internally; no wrap beyond DEPTH-1.
// TESTING
//  1 Reset: rst=0 after writes -> all rdata=0 before next clk edge, busy=0.
//  2 Write 0xDEADBEEF to 5, read 5 on both ports next cycle -> 0xDEADBEEF.
//    Same-cycle raddr=5 during write of 0x1234 -> rdata=0x1234 (forward).
//  3 ZERO_REG=1: write 0xFFFFFFFF to 0 -> wr_drop=1, rdata(0)=0.
//    ZERO_REG=0: same write -> read back 0xFFFFFFFF.
//  4 Fill all 32 entries with i+1, pulse clear_req one cycle -> busy high 32 cycles.
//    Mid-way entries <idx read 0 and others i+1; afterwards all 0.
//  5 Write to 7 during busy -> wr_drop=1, entry 7 stays 0 after clear.
//    clear_req during busy -> busy still ends after original 32 cycles.
//  6 Assert rst=0 at clear cycle 10 -> busy=0 immediately, all entries 0.
//    Write after release succeeds. DEPTH=24 variant: raddr=30 -> 0, we to 30 -> wr_drop=1.

Source files
------------

// File: rtl/reg_file_clr.sv
// Parametrised multi-port register file with optional hard-wired zero entry,
// write-to-read forwarding and a one-entry-per-cycle bulk-clear sequencer.
module reg_file_clr #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    input  logic                   clear_req,
    output logic                   busy,
    output logic                   wr_drop
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam bit          ZR      = (ZERO_REG != 0);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [AW:0]      idx;

    logic waddr_ok;
    logic wr_en;

    // Non-power-of-two depths leave addresses that map to no entry.
    assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
    assign wr_en    = we && (state == IDLE) && waddr_ok && !(ZR && (waddr == '0));
    assign wr_drop  = we && ((state == CLEAR) || !waddr_ok || (ZR && (waddr == '0)));
    assign busy     = (state == CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                CLEAR: begin
                    if (idx == LAST_W) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Writes only happen in IDLE, so they never collide with the clear sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[waddr] <= wdata;
            end
            if (state == CLEAR) begin
                mem[idx[AW-1:0]] <= '0;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        rdata = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = raddr[k*AW +: AW];
            if (!({1'b0, ra} < DEPTH_W) || (ZR && (ra == '0))) begin
                rdata[k*WIDTH +: WIDTH] = '0;
            end else if ((state == IDLE) && we && (waddr == ra)) begin
                rdata[k*WIDTH +: WIDTH] = wdata;
            end else begin
                rdata[k*WIDTH +: WIDTH] = mem[ra];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_clr.sv
// Scoreboard bench for reg_file_clr: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against three DUT configurations.
module tb_reg_file_clr;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        clear_req;

    logic [63:0] rdata_m, rdata_z, rdata_d;
    logic        busy_m, busy_z, busy_d;
    logic        drop_m, drop_z, drop_d;

    reg_file_clr #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_m), .clear_req(clear_req),
        .busy(busy_m), .wr_drop(drop_m)
    );

    reg_file_clr #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_z), .clear_req(clear_req),
        .busy(busy_z), .wr_drop(drop_z)
    );

    reg_file_clr #(.WIDTH(32), .DEPTH(24), .NREAD(2), .ZERO_REG(1)) dut_d24 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_d), .clear_req(clear_req),
        .busy(busy_d), .wr_drop(drop_d)
    );

    localparam int K_RD0   = 0;
    localparam int K_RD1   = 1;
    localparam int K_BUSY  = 2;
    localparam int K_DROP  = 3;
    localparam int K_Z0RD0 = 4;
    localparam int K_D24RD = 5;
    localparam int K_D24DR = 6;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD0:   return rdata_m[31:0];
            K_RD1:   return rdata_m[63:32];
            K_BUSY:  return {31'd0, busy_m};
            K_DROP:  return {31'd0, drop_m};
            K_Z0RD0: return rdata_z[31:0];
            K_D24RD: return rdata_d[31:0];
            K_D24DR: return {31'd0, drop_d};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: outputs are combinational, so every queued item is compared at the negedge.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.kind);
            vectors++;
            if (a !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL %s: got %h, want %h", e.name, a, e.exp);
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra0, input logic [4:0] ra1, input logic clr);
        @(posedge clk);
        #1;
        we        = w;
        waddr     = wa;
        wdata     = wd;
        raddr     = {ra1, ra0};
        clear_req = clr;
    endtask

    task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        raddr       = {5'd5, 5'd5};
        clear_req   = 1'b0;

        #1;
        checkOutput(K_RD0,  32'd0, "reset_rd0");
        checkOutput(K_BUSY, 32'd0, "reset_busy");
        checkOutput(K_DROP, 32'd0, "reset_drop");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Plain write with same-cycle forward, then registered readback
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
        checkOutput(K_RD0,  32'hDEADBEEF, "fwd_deadbeef");
        checkOutput(K_DROP, 32'd0,        "write5_nodrop");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0);
        checkOutput(K_RD0, 32'hDEADBEEF, "read5_p0");
        checkOutput(K_RD1, 32'hDEADBEEF, "read5_p1");

        applyStimulus(1'b1, 5'd5, 32'h00001234, 5'd5, 5'd3, 1'b0);
        checkOutput(K_RD0, 32'h00001234, "fwd_1234");
        checkOutput(K_RD1, 32'd0,        "read3_empty");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0);
        checkOutput(K_RD0, 32'h00001234, "read5_after_1234");

        // Entry 0: hard zero versus ordinary
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        checkOutput(K_DROP,  32'd1,        "zero_reg_drop");
        checkOutput(K_RD0,   32'd0,        "zero_reg_fwd_blocked");
        checkOutput(K_Z0RD0, 32'hFFFFFFFF, "z0_fwd");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        checkOutput(K_RD0,   32'd0,        "zero_reg_read");
        checkOutput(K_Z0RD0, 32'hFFFFFFFF, "z0_read");

        // Async reset clears everything before the next edge
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0);
        rst = 1'b0;
        checkOutput(K_RD0,   32'd0, "async_rst_rd5");
        checkOutput(K_BUSY,  32'd0, "async_rst_busy");
        checkOutput(K_Z0RD0, 32'd0, "async_rst_z0_rd0");
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i + 1), 5'd0, 5'd0, 1'b0);
        end

        applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd1, 1'b1);
        checkOutput(K_RD0,  32'd32, "filled_31");
        checkOutput(K_RD1,  32'd2,  "filled_1");
        checkOutput(K_BUSY, 32'd0,  "busy_before_clear");

        for (int m = 0; m < 32; m++) begin
            if (m == 5) begin
                applyStimulus(1'b1, 5'd7, 32'h77777777, 5'd7, 5'd4, 1'b0);
                checkOutput(K_DROP, 32'd1, "write_during_clear_drop");
                checkOutput(K_RD0,  32'd8, "clear_no_forward_7");
                checkOutput(K_RD1,  32'd0, "clear_partial_4");
            end else if (m == 16) begin
                applyStimulus(1'b0, 5'd0, 32'd0, 5'd15, 5'd16, 1'b0);
                checkOutput(K_RD0, 32'd0,  "clear_mid_15");
                checkOutput(K_RD1, 32'd17, "clear_mid_16");
            end else if (m == 20) begin
                applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
            end else begin
                applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
            end
            checkOutput(K_BUSY, 32'd1, $sformatf("busy_cycle_%0d", m));
        end

        applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd31, 1'b0);
        checkOutput(K_BUSY, 32'd0, "busy_done");
        checkOutput(K_RD0,  32'd0, "after_clear_7");
        checkOutput(K_RD1,  32'd0, "after_clear_31");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd20, 1'b0);
        checkOutput(K_BUSY, 32'd0, "no_restart");
        checkOutput(K_RD0,  32'd0, "after_clear_1");
        checkOutput(K_RD1,  32'd0, "after_clear_20");

        // Reset in the middle of a clear sweep
        applyStimulus(1'b1, 5'd20, 32'h000000AA, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd25, 32'h000000BB, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        for (int m = 0; m < 10; m++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 5'd20, 5'd25, 1'b0);
        end
        checkOutput(K_RD0,  32'h000000AA, "pre_rst_20");
        checkOutput(K_RD1,  32'h000000BB, "pre_rst_25");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd20, 5'd25, 1'b0);
        rst = 1'b0;
        checkOutput(K_BUSY, 32'd0, "midclear_rst_busy");
        checkOutput(K_RD0,  32'd0, "midclear_rst_20");
        checkOutput(K_RD1,  32'd0, "midclear_rst_25");
        applyStimulus(1'b1, 5'd20, 32'h00000055, 5'd20, 5'd25, 1'b0);
        rst = 1'b1;
        checkOutput(K_RD0,  32'h00000055, "post_rst_fwd");
        checkOutput(K_DROP, 32'd0,        "post_rst_nodrop");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd20, 5'd25, 1'b0);
        checkOutput(K_RD0,  32'h00000055, "post_rst_read20");
        checkOutput(K_RD1,  32'd0,        "post_rst_read25");
        checkOutput(K_BUSY, 32'd0,        "post_rst_busy");

        // Addresses beyond a non-power-of-two depth
        applyStimulus(1'b1, 5'd30, 32'h0000CAFE, 5'd30, 5'd0, 1'b0);
        checkOutput(K_D24DR, 32'd1,         "d24_drop_30");
        checkOutput(K_D24RD, 32'd0,         "d24_read_30");
        checkOutput(K_DROP,  32'd0,         "d32_nodrop_30");
        checkOutput(K_RD0,   32'h0000CAFE,  "d32_fwd_30");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd30, 5'd0, 1'b0);
        checkOutput(K_D24RD, 32'd0,         "d24_read_30_after");
        checkOutput(K_RD0,   32'h0000CAFE,  "d32_read_30");

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares += q.size();
            $display("[TB] FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
